scram_cfg_arb: RTL and testbench
================================

Name: scram_cfg_arb

Overview:
- Sequences and shares the scrambler control-packet port (sc_ctrl_pkt_d/dval/eof, scram_clr) among NUM_REQ configuration requesters, e.g. host CPU, crypto-period key rotator and PID table loader.
- Serialises each granted 96-bit request {address[15:0], scram_pid[15:0], cw[63:0]} into six 16-bit words, then an eof pulse.
- Runs the PID-table clear sweep on demand.
- Sits between the config masters and the scrambler configuration block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PIDRAM_DEPTH_BIT, 6, log2 of PID table depth; the clear sweep lasts 2**PIDRAM_DEPTH_BIT cycles.
- PKT_WORDS, 6, 16-bit words per control packet (fixed; a parameter only for visibility).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester level request; held until its ack.
- req_pkt  in  NUM_REQ*96  packed packets; requester i occupies bits [96*i+95:96*i] as {addr,pid,cw}; stable while req[i]=1.
- ack  out  NUM_REQ  one-cycle pulse: packet i captured; requester may change req_pkt or drop req.
- clr_req  in  1  single-cycle pulse: request a full PID-table clear.
- scram_clr  out  1  clear strobe to the scrambler configuration block.
- sc_ctrl_pkt_d  out  16  control word.
- sc_ctrl_pkt_dval  out  1  word valid.
- sc_ctrl_pkt_eof  out  1  end-of-packet pulse, never coincident with dval.
- grant_id  out  3  index of the requester being served (valid while busy in SEND/EOF).
- busy  out  1  not in IDLE.
- drop_err  out  1  one-cycle pulse: packet discarded because addr[15:PIDRAM_DEPTH_BIT] != 0.

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0; round-robin pointer last=NUM_REQ-1 (requester 0 wins first); clr_pend=0.
- States:
  - IDLE: if clr_pend or clr_req -> CLR. Else if any req -> SEND, latching the winner's packet. Else stay.
  - CLR: scram_clr=1 for exactly 2**PIDRAM_DEPTH_BIT consecutive cycles (counter 0..2**N-1), then -> IDLE. The downstream write address increments once per strobe and wraps, so every entry is written with 0. clr_pend clears on entry.
  - SEND: word counter w=0..5. Drives sc_ctrl_pkt_d = addr, pid, cw[63:48], cw[47:32], cw[31:16], cw[15:0] for w=0..5, with dval=1 each cycle. After w=5 -> EOF.
  - EOF: eof=1, dval=0, d=0 for one cycle -> IDLE.
- Timing:
  - Request seen in IDLE at cycle T: ack[i] and word0 at T+1, word5 at T+6, eof at T+7, IDLE at T+8.
  - Minimum packet spacing is 8 cycles; back-to-back requests give word0 again at T+9.
- Arbitration: round-robin, evaluated only in IDLE. Search order is last+1, last+2, ... modulo NUM_REQ; last updates to the winner on grant. No requester waits more than NUM_REQ grants.
- Address check:
  - If the latched addr[15:PIDRAM_DEPTH_BIT] != 0: ack still pulses at T+1, drop_err pulses at T+1, no dval/eof is emitted, and the block returns to IDLE at T+2.
  - The last pointer still advances.
- clr_req arriving in SEND/EOF/CLR sets clr_pend. A pending or new clear has priority over req in IDLE. Multiple clr_req during one CLR collapse into one further sweep.
- req deasserted before ack is undefined requester behaviour; the block still completes any packet already latched.
- grant_id is held from the grant through EOF.
- sc_ctrl_pkt_d is 0 whenever dval=0.
- Reset mid-packet: outputs return to 0 immediately. A partially sent packet is abandoned; the downstream word counter recovers on the next eof. There is no ack for an unlatched request.

Decomposition:
- Package scram_cfg_pkg: state encoding (IDLE, CLR, SEND, EOF), PKT_WORDS=6, packet field offsets (ADDR 95:80, PID 79:64, CW 63:0), PID valid bit 15 and parity bit 14 constants.
- Sub-module scram_rr_arb: combinational round-robin select over req with registered last pointer; outputs one-hot grant and index. The top level holds the FSM, packet register, word/clear counters and clr_pend.

Test Plan:
- Reset then single req[0], pkt {0x0005,0xC123,0x1122334455667788}: ack[0] at T+1; dval words 0005,C123,1122,3344,5566,7788 at T+1..T+6; eof at T+7 with dval=0.
- req=4'b1111 held, packets re-requested after each ack: grants in order 0,1,2,3,0. Each word0 is 8 cycles after the previous one; grant_id matches.
- clr_req pulse in IDLE: scram_clr high exactly 64 cycles; busy=1 throughout; no dval.
- clr_req at word2 of a packet while req[1] pending: packet completes with eof, then 64-cycle CLR, then req[1] is served.
- req[2] with addr=0x0040: ack[2] and drop_err at T+1; no dval or eof; IDLE at T+2.
- rst asserted at word3: all outputs 0 asynchronously. After release, req[0] wins first and the full packet is sent correctly.

Source files
------------

// File: rtl/scram_cfg_pkg.sv
// Shared types and constants for the scrambler config arbiter.
// State encoding, packet field offsets and the word serialiser.
package scram_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_SEND = 2'd2,
    ST_EOF  = 2'd3
  } state_e;

  localparam int PKT_WORDS = 6;
  localparam int PKT_BITS  = 96;

  localparam int ADDR_HI = 95;
  localparam int ADDR_LO = 80;
  localparam int PID_HI  = 79;
  localparam int PID_LO  = 64;
  localparam int CW_HI   = 63;
  localparam int CW_LO   = 0;

  localparam int PID_VALID_BIT  = 15;
  localparam int PID_PARITY_BIT = 14;

  function automatic logic [15:0] pkt_word(
    input logic [PKT_BITS-1:0] pkt,
    input logic [2:0]          w
  );
    logic [15:0] r;
    unique case (w)
      3'd0:    r = pkt[ADDR_HI:ADDR_LO];
      3'd1:    r = pkt[PID_HI:PID_LO];
      3'd2:    r = pkt[CW_HI:CW_HI-15];
      3'd3:    r = pkt[CW_HI-16:CW_HI-31];
      3'd4:    r = pkt[CW_HI-32:CW_HI-47];
      3'd5:    r = pkt[CW_LO+15:CW_LO];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scram_cfg_arb_rr.sv
// Round-robin selector: combinational pick, registered last pointer.
// Ports: req in, upd commits grant; gnt one-hot, gnt_idx, gnt_vld out.
module scram_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_idx,
  output logic               gnt_vld
);

  logic [2:0] last_q, last_d;
  int         idx;

  // Search last+1, last+2, ... modulo NUM_REQ
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!gnt_vld && j == idx && req[j]) begin
          gnt_vld = 1'b1;
          gnt_idx = 3'(j);
        end
      end
    end
  end

  assign gnt = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    last_d = last_q;
    if (upd && gnt_vld) last_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 3'(NUM_REQ - 1);
    else      last_q <= last_d;
  end

endmodule

// File: rtl/scram_cfg_arb.sv
// Shares the scrambler control-packet port among config requesters.
// Ports: req/req_pkt/ack per requester, clr_req, sc_ctrl_pkt_*, status.
module scram_cfg_arb #(
  parameter int NUM_REQ          = 4,
  parameter int PIDRAM_DEPTH_BIT = 6,
  parameter int PKT_WORDS        = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*96-1:0] req_pkt,
  output logic [NUM_REQ-1:0]    ack,
  input  logic                  clr_req,
  output logic                  scram_clr,
  output logic [15:0]           sc_ctrl_pkt_d,
  output logic                  sc_ctrl_pkt_dval,
  output logic                  sc_ctrl_pkt_eof,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic                  drop_err
);

  import scram_cfg_pkg::*;

  state_e                      state_q, state_d;
  logic [2:0]                  w_q, w_d;
  logic [PIDRAM_DEPTH_BIT-1:0] cnt_q, cnt_d;
  logic [PKT_BITS-1:0]         pkt_q, pkt_d;
  logic                        pend_q, pend_d;
  logic [2:0]                  gid_q, gid_d;
  logic [NUM_REQ-1:0]          ack_q, ack_d;
  logic                        drop_q, drop_d;
  logic                        dval_q, dval_d;
  logic [15:0]                 dat_q, dat_d;
  logic                        eof_q, eof_d;
  logic                        sclr_q, sclr_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [2:0]          gnt_idx;
  logic                gnt_vld;
  logic                upd;
  logic [PKT_BITS-1:0] sel_pkt;
  logic                bad_addr;

  scram_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .upd    (upd),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld)
  );

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 3'(i)) sel_pkt = req_pkt[i*PKT_BITS +: PKT_BITS];
    end
  end

  // Address must fit the PID table
  assign bad_addr = |sel_pkt[ADDR_HI:ADDR_LO+PIDRAM_DEPTH_BIT];

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    pend_d  = pend_q | clr_req;
    gid_d   = gid_q;
    ack_d   = '0;
    drop_d  = 1'b0;
    dval_d  = 1'b0;
    dat_d   = '0;
    eof_d   = 1'b0;
    sclr_d  = 1'b0;
    upd     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q || clr_req) begin
          state_d = ST_CLR;
          cnt_d   = '0;
          sclr_d  = 1'b1;
          pend_d  = 1'b0;
        end else if (gnt_vld) begin
          upd   = 1'b1;
          ack_d = gnt;
          gid_d = gnt_idx;
          pkt_d = sel_pkt;
          if (bad_addr) begin
            // EOF with eof low gives the one idle-return cycle
            drop_d  = 1'b1;
            state_d = ST_EOF;
          end else begin
            state_d = ST_SEND;
            w_d     = '0;
            dval_d  = 1'b1;
            dat_d   = pkt_word(sel_pkt, 3'd0);
          end
        end
      end
      ST_CLR: begin
        if (&cnt_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          sclr_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_q == 3'(PKT_WORDS - 1)) begin
          state_d = ST_EOF;
          eof_d   = 1'b1;
        end else begin
          w_d    = w_q + 3'd1;
          dval_d = 1'b1;
          dat_d  = pkt_word(pkt_q, w_q + 3'd1);
        end
      end
      ST_EOF: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      pkt_q   <= '0;
      pend_q  <= 1'b0;
      gid_q   <= '0;
      ack_q   <= '0;
      drop_q  <= 1'b0;
      dval_q  <= 1'b0;
      dat_q   <= '0;
      eof_q   <= 1'b0;
      sclr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      pend_q  <= pend_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
      dval_q  <= dval_d;
      dat_q   <= dat_d;
      eof_q   <= eof_d;
      sclr_q  <= sclr_d;
    end
  end

  assign ack              = ack_q;
  assign drop_err         = drop_q;
  assign sc_ctrl_pkt_dval = dval_q;
  assign sc_ctrl_pkt_d    = dat_q;
  assign sc_ctrl_pkt_eof  = eof_q;
  assign scram_clr        = sclr_q;
  assign grant_id         = gid_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scram_cfg_arb.sv
// Directed bench for scram_cfg_arb.
// Vector table plus hand-written multi-cycle sequences.
module tb_scram_cfg_arb;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [383:0] req_pkt;
  logic [3:0]   ack;
  logic         clr_req;
  logic         scram_clr;
  logic [15:0]  sc_ctrl_pkt_d;
  logic         sc_ctrl_pkt_dval;
  logic         sc_ctrl_pkt_eof;
  logic [2:0]   grant_id;
  logic         busy;
  logic         drop_err;

  int checks;
  int failures;

  scram_cfg_arb #(
    .NUM_REQ(4),
    .PIDRAM_DEPTH_BIT(6),
    .PKT_WORDS(6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_pkt         (req_pkt),
    .ack             (ack),
    .clr_req         (clr_req),
    .scram_clr       (scram_clr),
    .sc_ctrl_pkt_d   (sc_ctrl_pkt_d),
    .sc_ctrl_pkt_dval(sc_ctrl_pkt_dval),
    .sc_ctrl_pkt_eof (sc_ctrl_pkt_eof),
    .grant_id        (grant_id),
    .busy            (busy),
    .drop_err        (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        dval;
    logic [15:0] d;
    logic        eof;
    logic        busy;
    logic        drop;
    logic [2:0]  gid;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(
    input logic [3:0] r, input logic [3:0] a,
    input logic v, input logic [15:0] d,
    input logic e, input logic b,
    input logic dr, input logic [2:0] g
  );
    vec_t x;
    x.req = r; x.ack = a; x.dval = v; x.d = d;
    x.eof = e; x.busy = b; x.drop = dr; x.gid = g;
    return x;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    clr_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_pkt(input int i, input logic [15:0] a,
                         input logic [15:0] p,
                         input logic [63:0] cw);
    req_pkt[i*96 +: 96] = {a, p, cw};
  endtask

  function automatic logic [31:0] all_out();
    return {ack, sc_ctrl_pkt_dval, sc_ctrl_pkt_d,
            sc_ctrl_pkt_eof, scram_clr, busy,
            drop_err, grant_id};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dv, bm, first, eofc, ackc;
    logic [15:0] ackd;
    logic [15:0] w3[6];
    int at_prev;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    req = '0;
    clr_req = 1'b0;
    req_pkt = '0;
    set_pkt(0, 16'h0005, 16'hC123, 64'h1122334455667788);
    set_pkt(1, 16'h0011, 16'h0101, 64'h0);
    set_pkt(2, 16'h0040, 16'h0202, 64'h0);
    set_pkt(3, 16'h0033, 16'h0303, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_outs", 64'(all_out()), 64'h0);
    rst = 1'b1;

    // single packet then out-of-range drop
    tbl[0]  = mk(4'h1, 4'h1, 1, 16'h0005, 0, 1, 0, 0);
    tbl[1]  = mk(4'h0, 4'h0, 1, 16'hC123, 0, 1, 0, 0);
    tbl[2]  = mk(4'h0, 4'h0, 1, 16'h1122, 0, 1, 0, 0);
    tbl[3]  = mk(4'h0, 4'h0, 1, 16'h3344, 0, 1, 0, 0);
    tbl[4]  = mk(4'h0, 4'h0, 1, 16'h5566, 0, 1, 0, 0);
    tbl[5]  = mk(4'h0, 4'h0, 1, 16'h7788, 0, 1, 0, 0);
    tbl[6]  = mk(4'h0, 4'h0, 0, 16'h0000, 1, 1, 0, 0);
    tbl[7]  = mk(4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[8]  = mk(4'h4, 4'h4, 0, 16'h0000, 0, 1, 1, 2);
    tbl[9]  = mk(4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 2);
    tbl[10] = mk(4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 2);
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("v%0d_ack", i), 64'(ack), 64'(tbl[i].ack));
      chk($sformatf("v%0d_dval", i), 64'(sc_ctrl_pkt_dval),
          64'(tbl[i].dval));
      chk($sformatf("v%0d_d", i), 64'(sc_ctrl_pkt_d), 64'(tbl[i].d));
      chk($sformatf("v%0d_eof", i), 64'(sc_ctrl_pkt_eof),
          64'(tbl[i].eof));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("v%0d_drop", i), 64'(drop_err), 64'(tbl[i].drop));
      chk($sformatf("v%0d_gid", i), 64'(grant_id), 64'(tbl[i].gid));
      chk($sformatf("v%0d_clr", i), 64'(scram_clr), 64'h0);
    end

    // round robin with all requests held
    set_pkt(2, 16'h0022, 16'h0202, 64'h0);
    do_reset();
    req = 4'hF;
    n = 0;
    at_prev = -1;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (ack != 4'h0 && n < 5) begin
        chk($sformatf("rr%0d_ack", n), 64'(ack), 64'(4'h1 << (n % 4)));
        chk($sformatf("rr%0d_gid", n), 64'(grant_id), 64'(n % 4));
        chk($sformatf("rr%0d_w0", n), 64'(sc_ctrl_pkt_d),
            64'(req_pkt[(n % 4)*96+80 +: 16]));
        if (at_prev >= 0)
          chk($sformatf("rr%0d_gap", n), 64'(c - at_prev), 64'd8);
        at_prev = c;
        n++;
      end
    end
    chk("rr_count", 64'(n), 64'd5);
    req = '0;
    for (int c = 0; c < 10; c++) tick();

    // clear sweep from idle
    do_reset();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_first", 64'(scram_clr), 64'h1);
    n = 0; dv = 0; bm = 0;
    for (int c = 0; c < 80; c++) begin
      if (scram_clr) n++;
      if (sc_ctrl_pkt_dval) dv++;
      if (busy !== scram_clr) bm++;
      tick();
    end
    chk("clr_len", 64'(n), 64'd64);
    chk("clr_dval", 64'(dv), 64'd0);
    chk("clr_busy", 64'(bm), 64'd0);

    // clear request mid-packet with req[1] waiting
    do_reset();
    req = 4'h1;
    tick();
    req = 4'h2;
    tick();
    tick();
    chk("mid_w2", 64'(sc_ctrl_pkt_d), 64'h1122);
    n = 0; first = -1; eofc = -1; ackc = -1; ackd = '0;
    for (int c = 0; c < 80; c++) begin
      if (sc_ctrl_pkt_eof && eofc < 0) eofc = c;
      if (scram_clr) begin
        if (first < 0) first = c;
        n++;
      end
      if (ack[1] && ackc < 0) begin
        ackc = c;
        ackd = sc_ctrl_pkt_d;
        req = 4'h0;
      end
      clr_req = (c == 0);
      tick();
    end
    chk("mid_eof_at", 64'(eofc), 64'd4);
    chk("mid_clr_at", 64'(first), 64'd6);
    chk("mid_clr_len", 64'(n), 64'd64);
    chk("mid_ack1_at", 64'(ackc), 64'd71);
    chk("mid_ack1_w0", 64'(ackd), 64'h0011);

    // reset in the middle of a packet
    do_reset();
    req = 4'h1;
    tick();
    req = 4'h0;
    tick();
    tick();
    tick();
    chk("rst_pre_w3", 64'(sc_ctrl_pkt_d), 64'h3344);
    req = 4'h3;
    rst = 1'b0;
    #2;
    chk("rst_async", 64'(all_out()), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk("rst_ack", 64'(ack), 64'h1);
    chk("rst_gid", 64'(grant_id), 64'h0);
    chk("rst_w0", 64'(sc_ctrl_pkt_d), 64'h0005);
    req = 4'h2;
    w3[0] = 16'h0005; w3[1] = 16'hC123; w3[2] = 16'h1122;
    w3[3] = 16'h3344; w3[4] = 16'h5566; w3[5] = 16'h7788;
    for (int k = 1; k < 6; k++) begin
      tick();
      chk($sformatf("rst_w%0d", k), 64'(sc_ctrl_pkt_d), 64'(w3[k]));
      chk($sformatf("rst_v%0d", k), 64'(sc_ctrl_pkt_dval), 64'h1);
    end
    tick();
    chk("rst_eof", 64'(sc_ctrl_pkt_eof), 64'h1);
    chk("rst_eof_dval", 64'(sc_ctrl_pkt_dval), 64'h0);
    req = 4'h0;
    for (int c = 0; c < 10; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
